// File: rtl/alarm_pkg.sv
// Shared definitions for the alarm sequencer: state encodings, default
// timing constants and a counter-width helper.
package alarm_pkg;

    // Fixed 3-bit state encodings seen on state_o.
    localparam logic [2:0] ENC_DISARMED = 3'd0;
    localparam logic [2:0] ENC_EXIT     = 3'd1;
    localparam logic [2:0] ENC_ARMED    = 3'd2;
    localparam logic [2:0] ENC_ENTRY    = 3'd3;
    localparam logic [2:0] ENC_ALARM    = 3'd4;

    typedef enum logic [2:0] {
        ST_DISARMED = ENC_DISARMED,
        ST_EXIT     = ENC_EXIT,
        ST_ARMED    = ENC_ARMED,
        ST_ENTRY    = ENC_ENTRY,
        ST_ALARM    = ENC_ALARM
    } state_e;

    // Default timebase: 1 ms ticks from a 25 MHz clock.
    localparam int DEF_TICK_CYCLES    = 25000;
    localparam int DEF_DEBOUNCE_TICKS = 20;
    localparam int DEF_EXIT_TICKS     = 10000;
    localparam int DEF_ENTRY_TICKS    = 5000;
    localparam int DEF_ALARM_TICKS    = 60000;
    localparam int DEF_BLINK_TICKS    = 250;
    localparam int DEF_TONE_HALF      = 12500;

    // Bits needed to hold any value from 0 up to and including 'value'.
    function automatic int width_for(input int value);
        return (value < 2) ? 1 : $clog2(value + 1);
    endfunction

endpackage

// File: rtl/input_debounce.sv
// Two-flop synchroniser followed by a tick-based debouncer. The debounced
// level only follows the synchronised input once the two have disagreed on
// DEBOUNCE_TICKS consecutive tick strobes.
module input_debounce
    import alarm_pkg::*;
#(
    parameter int DEBOUNCE_TICKS = DEF_DEBOUNCE_TICKS
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_i,
    input  logic tick_i,
    output logic level_o
);

    localparam int CW = width_for(DEBOUNCE_TICKS);

    logic          sync1_q;
    logic          sync2_q;
    logic          level_q;
    logic          level_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Bring the asynchronous board input into the clk domain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
        end
    end

    // Count consecutive strobes on which the input disagrees; any agreeing strobe restarts the count.
    always_comb begin
        level_d = level_q;
        cnt_d   = cnt_q;
        if (tick_i) begin
            if (sync2_q != level_q) begin
                if (cnt_q == CW'(DEBOUNCE_TICKS - 1)) begin
                    level_d = sync2_q;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end else begin
                cnt_d = '0;
            end
        end
    end

    // Debounce state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level_o = level_q;

endmodule

// File: rtl/alarm_sequencer.sv
// Arming/alarm controller: debounces the board inputs, runs the
// disarmed/exit/armed/entry/alarm state machine and drives the LED,
// siren tone and message trigger from registered outputs.
module alarm_sequencer
    import alarm_pkg::*;
#(
    parameter int TICK_CYCLES    = DEF_TICK_CYCLES,
    parameter int DEBOUNCE_TICKS = DEF_DEBOUNCE_TICKS,
    parameter int EXIT_TICKS     = DEF_EXIT_TICKS,
    parameter int ENTRY_TICKS    = DEF_ENTRY_TICKS,
    parameter int ALARM_TICKS    = DEF_ALARM_TICKS,
    parameter int BLINK_TICKS    = DEF_BLINK_TICKS,
    parameter int TONE_HALF      = DEF_TONE_HALF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sw_on,
    input  logic       gases,
    input  logic       movimiento,
    input  logic       clave,
    output logic       led,
    output logic       sound,
    output logic       mensaje,
    output logic [2:0] state_o
);

    localparam int TMAX_EE = (EXIT_TICKS > ENTRY_TICKS) ? EXIT_TICKS : ENTRY_TICKS;
    localparam int TMAX    = (TMAX_EE > ALARM_TICKS) ? TMAX_EE : ALARM_TICKS;
    localparam int PW      = width_for(TICK_CYCLES);
    localparam int TW      = width_for(TMAX);
    localparam int BW      = width_for(BLINK_TICKS);
    localparam int NW      = width_for(TONE_HALF);

    logic          tick;
    logic          sw_db;
    logic          gas_db;
    logic          mov_db;
    logic          clave_db;
    logic          clave_prev_q;
    logic          clave_ev;
    logic          expire;
    logic          reload;
    logic          state_change;
    logic          alarm_entry;

    state_e        state_q;
    state_e        state_d;
    logic [PW-1:0] presc_q;
    logic [PW-1:0] presc_d;
    logic [TW-1:0] timer_q;
    logic [TW-1:0] timer_d;
    logic [BW-1:0] blink_cnt_q;
    logic [BW-1:0] blink_cnt_d;
    logic          blink_q;
    logic          blink_d;
    logic [NW-1:0] tone_cnt_q;
    logic [NW-1:0] tone_cnt_d;
    logic          tone_q;
    logic          tone_d;
    logic [PW-1:0] msg_cnt_q;
    logic [PW-1:0] msg_cnt_d;
    logic          led_q;
    logic          led_d;
    logic          sound_q;
    logic          sound_d;
    logic          mensaje_q;
    logic [2:0]    state_o_q;

    input_debounce #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_sw_db (
        .clk(clk), .rst_n(rst_n), .raw_i(sw_on), .tick_i(tick), .level_o(sw_db)
    );
    input_debounce #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_gas_db (
        .clk(clk), .rst_n(rst_n), .raw_i(gases), .tick_i(tick), .level_o(gas_db)
    );
    input_debounce #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_mov_db (
        .clk(clk), .rst_n(rst_n), .raw_i(movimiento), .tick_i(tick), .level_o(mov_db)
    );
    input_debounce #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_clave_db (
        .clk(clk), .rst_n(rst_n), .raw_i(clave), .tick_i(tick), .level_o(clave_db)
    );

    assign tick     = (presc_q == PW'(TICK_CYCLES - 1));
    assign clave_ev = clave_db & ~clave_prev_q;
    assign expire   = tick && (timer_q == TW'(1));

    // Next state: gas overrides everything, then code events, then sw_on/motion, then expiry.
    always_comb begin
        state_d = state_q;
        reload  = 1'b0;
        if (gas_db) begin
            state_d = ST_ALARM;
            reload  = (state_q == ST_ALARM) && expire;
        end else begin
            case (state_q)
                ST_DISARMED: begin
                    if (sw_db) state_d = ST_EXIT;
                end
                ST_EXIT: begin
                    if (clave_ev || !sw_db) state_d = ST_DISARMED;
                    else if (expire)        state_d = ST_ARMED;
                end
                ST_ARMED: begin
                    if (clave_ev)    state_d = ST_DISARMED;
                    else if (mov_db) state_d = ST_ENTRY;
                end
                ST_ENTRY: begin
                    if (clave_ev)    state_d = ST_DISARMED;
                    else if (expire) state_d = ST_ALARM;
                end
                ST_ALARM: begin
                    if (clave_ev)    state_d = ST_DISARMED;
                    else if (expire) state_d = ST_ARMED;
                end
                default: state_d = ST_DISARMED;
            endcase
        end
    end

    assign state_change = (state_d != state_q);
    assign alarm_entry  = (state_d == ST_ALARM) && (state_q != ST_ALARM);

    // Prescaler, state timer, blink, tone and message counters.
    always_comb begin
        presc_d     = tick ? '0 : presc_q + PW'(1);

        timer_d     = timer_q;
        if (state_change || reload) begin
            case (state_d)
                ST_EXIT:  timer_d = TW'(EXIT_TICKS);
                ST_ENTRY: timer_d = TW'(ENTRY_TICKS);
                ST_ALARM: timer_d = TW'(ALARM_TICKS);
                default:  timer_d = '0;
            endcase
        end else if (tick && (timer_q != '0)) begin
            timer_d = timer_q - TW'(1);
        end

        blink_cnt_d = blink_cnt_q;
        blink_d     = blink_q;
        if (state_change) begin
            blink_cnt_d = '0;
            blink_d     = 1'b1;
        end else if (tick) begin
            if (blink_cnt_q == BW'(BLINK_TICKS - 1)) begin
                blink_cnt_d = '0;
                blink_d     = ~blink_q;
            end else begin
                blink_cnt_d = blink_cnt_q + BW'(1);
            end
        end

        tone_cnt_d  = tone_cnt_q;
        tone_d      = tone_q;
        if (alarm_entry) begin
            tone_cnt_d = '0;
            tone_d     = 1'b0;
        end else if (state_q == ST_ALARM) begin
            if (tone_cnt_q == NW'(TONE_HALF - 1)) begin
                tone_cnt_d = '0;
                tone_d     = ~tone_q;
            end else begin
                tone_cnt_d = tone_cnt_q + NW'(1);
            end
        end

        msg_cnt_d   = msg_cnt_q;
        if (alarm_entry && (msg_cnt_q == '0)) begin
            msg_cnt_d = PW'(TICK_CYCLES);
        end else if (msg_cnt_q != '0) begin
            msg_cnt_d = msg_cnt_q - PW'(1);
        end
    end

    // Output decode from the current state, registered one cycle later.
    always_comb begin
        led_d   = 1'b0;
        sound_d = 1'b0;
        case (state_q)
            ST_ARMED:                    led_d = 1'b1;
            ST_EXIT, ST_ENTRY, ST_ALARM: led_d = blink_q;
            default:                     led_d = 1'b0;
        endcase
        if (state_q == ST_ALARM) sound_d = tone_q;
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_DISARMED;
            clave_prev_q <= 1'b0;
            presc_q      <= '0;
            timer_q      <= '0;
            blink_cnt_q  <= '0;
            blink_q      <= 1'b0;
            tone_cnt_q   <= '0;
            tone_q       <= 1'b0;
            msg_cnt_q    <= '0;
            led_q        <= 1'b0;
            sound_q      <= 1'b0;
            mensaje_q    <= 1'b0;
            state_o_q    <= ENC_DISARMED;
        end else begin
            state_q      <= state_d;
            clave_prev_q <= clave_db;
            presc_q      <= presc_d;
            timer_q      <= timer_d;
            blink_cnt_q  <= blink_cnt_d;
            blink_q      <= blink_d;
            tone_cnt_q   <= tone_cnt_d;
            tone_q       <= tone_d;
            msg_cnt_q    <= msg_cnt_d;
            led_q        <= led_d;
            sound_q      <= sound_d;
            mensaje_q    <= (msg_cnt_q != '0);
            state_o_q    <= state_q;
        end
    end

    assign led     = led_q;
    assign sound   = sound_q;
    assign mensaje = mensaje_q;
    assign state_o = state_o_q;

endmodule

// File: tb/tb_alarm_sequencer.sv
// Self-checking bench for alarm_sequencer using short timing parameters.
module tb_alarm_sequencer;

    localparam logic [2:0] S_DIS  = 3'd0;
    localparam logic [2:0] S_EXIT = 3'd1;
    localparam logic [2:0] S_ARM  = 3'd2;
    localparam logic [2:0] S_ENT  = 3'd3;
    localparam logic [2:0] S_ALM  = 3'd4;

    logic       clk        = 1'b0;
    logic       rst_n      = 1'b0;
    logic       sw_on      = 1'b0;
    logic       gases      = 1'b0;
    logic       movimiento = 1'b0;
    logic       clave      = 1'b0;
    logic       led;
    logic       sound;
    logic       mensaje;
    logic [2:0] state_o;

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct {
        logic       sw;
        logic       gas;
        logic       mov;
        logic       clv;
        int         cycles;
        logic [2:0] exp_state;
        logic       chk_led;
        logic       exp_led;
        logic       chk_snd;
        logic       exp_snd;
        logic       exp_msg;
    } vec_t;

    vec_t vecs [8];

    alarm_sequencer #(
        .TICK_CYCLES(4), .DEBOUNCE_TICKS(2), .EXIT_TICKS(10), .ENTRY_TICKS(5),
        .ALARM_TICKS(20), .BLINK_TICKS(2), .TONE_HALF(3)
    ) dut (
        .clk(clk), .rst_n(rst_n), .sw_on(sw_on), .gases(gases),
        .movimiento(movimiento), .clave(clave), .led(led), .sound(sound),
        .mensaje(mensaje), .state_o(state_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: time limit reached, got no finish, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic applyStimulus(input logic s, input logic g, input logic m, input logic c, input int n);
        sw_on      = s;
        gases      = g;
        movimiento = m;
        clave      = c;
        repeat (n) @(negedge clk);
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        tests_run++;
        if (actual != expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic checkRange(input string name, input int actual, input int lo, input int hi);
        tests_run++;
        if (actual < lo || actual > hi) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d..%0d", name, actual, lo, hi);
        end
    endtask

    task automatic waitState(input logic [2:0] exp, input int budget, input string name);
        int  n   = 0;
        bit  hit = 1'b0;
        while (!hit && n < budget) begin
            @(negedge clk);
            n++;
            if (state_o == exp) hit = 1'b1;
        end
        checkOutput(name, int'(state_o), int'(exp));
    endtask

    task automatic runVectors(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            applyStimulus(vecs[i].sw, vecs[i].gas, vecs[i].mov, vecs[i].clv, vecs[i].cycles);
            checkOutput($sformatf("vec%0d_state", i), int'(state_o), int'(vecs[i].exp_state));
            if (vecs[i].chk_led) checkOutput($sformatf("vec%0d_led", i), int'(led), int'(vecs[i].exp_led));
            if (vecs[i].chk_snd) checkOutput($sformatf("vec%0d_sound", i), int'(sound), int'(vecs[i].exp_snd));
            checkOutput($sformatf("vec%0d_mensaje", i), int'(mensaje), int'(vecs[i].exp_msg));
        end
    endtask

    initial begin
        logic msg_s [12];
        logic snd_s [12];
        logic led_s [20];
        int   cnt;
        int   aux;
        int   first;
        int   second;
        int   ntog;
        bit   done;
        logic prev;

        // sw gas mov clv cycles state chk_led led chk_snd snd msg
        vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 200, S_DIS,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 20,  S_EXIT, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 1'b0, 1'b0, 1'b0, 40,  S_ARM,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 1'b0, 1'b1, 1'b0, 3,   S_ARM,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 1'b0, 1'b0, 1'b0, 20,  S_ARM,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 20,  S_ARM,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 20,  S_DIS,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 20,  S_DIS,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

        // Reset values while reset is held.
        repeat (3) @(negedge clk);
        checkOutput("reset_state", int'(state_o), int'(S_DIS));
        checkOutput("reset_led", int'(led), 0);
        checkOutput("reset_sound", int'(sound), 0);
        checkOutput("reset_mensaje", int'(mensaje), 0);
        rst_n = 1'b1;

        // Idle, arm, exit delay, armed, short motion pulse rejected.
        runVectors(0, 4);

        // Motion held: entry delay, alarm with message pulse and tone, back to armed.
        movimiento = 1'b1;
        waitState(S_ENT, 20, "s3_entry");
        movimiento = 1'b0;
        waitState(S_ALM, 30, "s3_alarm");
        msg_s[0] = mensaje;
        snd_s[0] = sound;
        for (int i = 1; i < 12; i++) begin
            @(negedge clk);
            msg_s[i] = mensaje;
            snd_s[i] = sound;
        end
        checkOutput("s3_msg_first", int'(msg_s[0]), 1);
        cnt = 0;
        for (int i = 0; i < 12; i++) if (msg_s[i]) cnt++;
        checkOutput("s3_msg_width", cnt, 4);
        ntog = 0; first = -1; second = -1;
        for (int i = 1; i < 12; i++) begin
            if (snd_s[i] != snd_s[i-1]) begin
                if (ntog == 0) first = i;
                else if (ntog == 1) second = i;
                ntog++;
            end
        end
        checkOutput("s3_tone_toggles", ntog, 3);
        checkOutput("s3_tone_first", first, 3);
        checkOutput("s3_tone_period", second - first, 3);
        cnt = 12; done = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (state_o == S_ALM) cnt++;
            else done = 1'b1;
        end
        checkRange("s3_alarm_length", cnt, 77, 80);
        checkOutput("s3_back_armed", int'(state_o), int'(S_ARM));
        checkOutput("s3_armed_led", int'(led), 1);

        // sw_on ignored while armed, then code disarms.
        runVectors(5, 7);

        // Exit blink period, then sw_on dropped part-way through exit.
        sw_on = 1'b1;
        waitState(S_EXIT, 20, "s2_exit");
        led_s[0] = led;
        for (int i = 1; i < 20; i++) begin
            @(negedge clk);
            led_s[i] = led;
        end
        checkOutput("s2_blink_start", int'(led_s[0]), 1);
        ntog = 0; first = -1; second = -1;
        for (int i = 1; i < 20; i++) begin
            if (led_s[i] != led_s[i-1]) begin
                if (ntog == 0) first = i;
                else if (ntog == 1) second = i;
                ntog++;
            end
        end
        checkOutput("s2_blink_period", (ntog >= 2) ? (second - first) : -1, 8);
        sw_on = 1'b0;
        waitState(S_DIS, 20, "s2_abort");
        checkOutput("s2_abort_led", int'(led), 0);

        // Code event during entry delay aborts before the siren.
        sw_on = 1'b1;
        waitState(S_ARM, 100, "s4_armed");
        movimiento = 1'b1;
        waitState(S_ENT, 20, "s4_entry");
        movimiento = 1'b0;
        sw_on      = 1'b0;
        clave      = 1'b1;
        cnt = 0; aux = 0; done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (sound) cnt++;
            if (state_o == S_ALM) aux++;
            if (state_o == S_DIS) done = 1'b1;
        end
        checkOutput("s4_disarmed", int'(done), 1);
        checkOutput("s4_sound_cycles", cnt, 0);
        checkOutput("s4_alarm_cycles", aux, 0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 20);

        // Gas from disarmed, held across a timer reload: single message pulse.
        gases = 1'b1;
        waitState(S_ALM, 20, "s5_gas_alarm");
        cnt = mensaje ? 1 : 0;
        aux = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (mensaje) cnt++;
            if (state_o != S_ALM) aux++;
        end
        checkOutput("s5_msg_total", cnt, 4);
        checkOutput("s5_left_alarm", aux, 0);
        gases = 1'b0;
        waitState(S_ARM, 120, "s5_gas_clear");
        clave = 1'b1;
        waitState(S_DIS, 20, "s5_disarm");
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 20);

        // Gas and code event debounced together while in alarm: gas wins.
        sw_on = 1'b1;
        waitState(S_ARM, 100, "s6_armed");
        sw_on      = 1'b0;
        movimiento = 1'b1;
        waitState(S_ENT, 20, "s6_entry");
        movimiento = 1'b0;
        waitState(S_ALM, 30, "s6_alarm");
        gases = 1'b1;
        clave = 1'b1;
        prev = mensaje;
        cnt = 0; aux = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (mensaje && !prev) cnt++;
            prev = mensaje;
            if (state_o != S_ALM) aux++;
        end
        checkOutput("s6_left_alarm", aux, 0);
        checkOutput("s6_msg_retrigger", cnt, 0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 20);
        checkOutput("s6_still_alarm", int'(state_o), int'(S_ALM));
        clave = 1'b1;
        waitState(S_DIS, 20, "s6_disarm");
        checkOutput("s6_led_off", int'(led), 0);
        checkOutput("s6_sound_off", int'(sound), 0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 20);

        // Asynchronous reset in the middle of an alarm.
        gases = 1'b1;
        waitState(S_ALM, 20, "s1_alarm");
        checkOutput("s1_pre_mensaje", int'(mensaje), 1);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("s1_rst_state", int'(state_o), int'(S_DIS));
        checkOutput("s1_rst_led", int'(led), 0);
        checkOutput("s1_rst_sound", int'(sound), 0);
        checkOutput("s1_rst_mensaje", int'(mensaje), 0);
        gases = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 30);
        checkOutput("s1_after_state", int'(state_o), int'(S_DIS));
        checkOutput("s1_after_led", int'(led), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
